turn_ctrl: RTL and testbench
============================

# turn_ctrl

Game-flow controller sitting directly upstream of the board memory array. It accepts player moves, rejects illegal ones, and drives the memory's address/cell-state write port. After each accepted move it scans the eight winning lines of the returned game board, one line per cycle, and reports win, tie or turn change. Its `result` encoding matches the board conventions used across the design: player1 11, player2 10, tie 01, noWin 00.

## Interface
- No parameters. Board geometry is fixed at 3x3 with 2-bit cells.
- `ph1` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `moveValid` input 1: move request; sampled in IDLE only.
- `moveAddr` input 4: requested cell, 0..8 row-major, cell 8 = 4'b1000.
- `gameBoard` input 18: board from memory; cell i at [2i+1:2i]; 00 empty, 11 player1, 10 player2.
- `addr` output 4: memory write address.
- `cellState` output 2: memory write data. The memory writes it into the cell at `addr` every clock.
- `turn` output 1: player to move; 0 = player1, 1 = player2.
- `busy` output 1: high outside IDLE/DONE.
- `moveAck` output 1: one-cycle pulse; accepted move fully evaluated.
- `moveErr` output 1: one-cycle pulse; move rejected.
- `result` output 2: 00 noWin, 11 player1 win, 10 player2 win, 01 tie.
- `gameOver` output 1: high in DONE.

## Operation
- The memory has no write enable, so `cellState` must never corrupt a cell.
  - In IDLE, SCAN and DONE: `cellState` = gameBoard[2*addr+1 : 2*addr] (combinational write-back of the current content).
  - In WRITE and SETTLE: `cellState` = turn ? 2'b10 : 2'b11.
- States and transitions:
  - IDLE, moveValid=1, moveAddr>8 → moveErr, stay IDLE.
  - IDLE, moveValid=1, target cell ≠00 → moveErr, stay IDLE.
  - IDLE, legal move → latch `addr`=moveAddr, go to WRITE.
  - WRITE → SETTLE. SETTLE lets the board reflect the write.
  - SETTLE → SCAN with line index 0.
  - SCAN line j, three cells equal and ≠00 → `result`=that cell code, moveAck, go to DONE.
  - SCAN line 7, no match, moveCount==9 → `result`=01, moveAck, go to DONE.
  - SCAN line 7, no match, moveCount<9 → toggle `turn`, moveAck, go to IDLE.
  - SCAN otherwise → j+1.
  - DONE: held until reset. moveValid ignored; no moveErr.
- Line order: 0=(0,1,2), 1=(3,4,5), 2=(6,7,8), 3=(0,3,6), 4=(1,4,7), 5=(2,5,8), 6=(0,4,8), 7=(2,4,6).
- moveCount is 4 bits, increments on entering WRITE, range 0..9.
- `turn` does not change on a rejected move or on the winning move.
- moveValid while busy: ignored; it is not queued and raises no error.
- A rejected move leaves `addr` unchanged.

## Timing
- Reset values:
  - State IDLE, turn=0, addr=0, moveCount=0.
  - busy=0, moveAck=0, moveErr=0, result=00, gameOver=0.
  - `cellState` = gameBoard[1:0], which is 00 after memory reset.
- Legal move sampled at edge E0:
  - WRITE in cycle E0–E1; SETTLE in E1–E2.
  - SCAN line j in cycle E(2+j)–E(3+j).
- Win on line j: result/gameOver/moveAck visible after E(3+j).
- No win: moveAck visible after E10; new `turn` valid from E10.
- Worst-case move-to-IDLE latency: 10 cycles.
- moveErr asserts in the cycle after the sampling edge, for exactly one cycle.
- moveAck is exactly one cycle wide.
- `busy` is high from E0 until the edge that leaves SCAN.
- Reset asserted mid-operation (any state): immediate return to reset values, no pulse emitted. The memory clears in parallel.

## Test plan
- Reset, then move addr 4 → cellState=11 during WRITE/SETTLE; board[9:8]=11 after E2; moveAck after E10; turn=1; result=00.
- Move to occupied cell 4 (board[9:8]=11) → moveErr one cycle, turn unchanged, board unchanged. Separately, moveAddr=4'b1001 → moveErr.
- Player1 plays 0, 1, 2 interleaved with player2 on 3, 4 → on the final move, line 0 matches; result=11, gameOver=1, moveAck after E3; turn stays 0.
- Draw sequence 0,1,2,4,3,5,7,6,8 → ninth move gives result=01 after E10, gameOver=1; any later moveValid produces no ack and no err.
- moveValid held high during SCAN → no extra write; board unchanged apart from the accepted cell; cellState equals the addressed cell content each SCAN cycle.
- reset low during SCAN of line 3 → all outputs at reset values within the same cycle; next legal move behaves as the first move.

Source files
------------

// File: rtl/turn_ctrl_if.sv
// turn_ctrl move/board port bundle.
// master drives moves and returns the board; slave is the controller.
interface turn_ctrl_if;
  logic        moveValid;
  logic [3:0]  moveAddr;
  logic [17:0] gameBoard;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic        turn;
  logic        busy;
  logic        moveAck;
  logic        moveErr;
  logic [1:0]  result;
  logic        gameOver;

  modport master (
    output moveValid,
    output moveAddr,
    output gameBoard,
    input  addr,
    input  cellState,
    input  turn,
    input  busy,
    input  moveAck,
    input  moveErr,
    input  result,
    input  gameOver
  );

  modport slave (
    input  moveValid,
    input  moveAddr,
    input  gameBoard,
    output addr,
    output cellState,
    output turn,
    output busy,
    output moveAck,
    output moveErr,
    output result,
    output gameOver
  );
endinterface

// File: rtl/turn_ctrl.sv
// 3x3 game-flow controller: move legality, board write,
// line-by-line win/tie scan and turn handover.
module turn_ctrl (
  input logic        ph1,
  input logic        reset,
  turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SETTLE,
    SCAN,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  line;
  logic [3:0]  move_count;
  logic [3:0]  addr_q;
  logic        turn_q;
  logic        busy_q;
  logic        ack_q;
  logic        err_q;
  logic [1:0]  result_q;
  logic        over_q;

  logic [1:0]  cell_a;
  logic [1:0]  cell_b;
  logic [1:0]  cell_c;
  logic [11:0] line_cells;
  logic        line_match;
  logic [1:0]  target;
  logic [1:0]  cell_state;

  function automatic logic [1:0] cell_at(
    input logic [17:0] b,
    input logic [3:0]  i
  );
    logic [1:0] v;
    unique case (i)
      4'd0:    v = b[1:0];
      4'd1:    v = b[3:2];
      4'd2:    v = b[5:4];
      4'd3:    v = b[7:6];
      4'd4:    v = b[9:8];
      4'd5:    v = b[11:10];
      4'd6:    v = b[13:12];
      4'd7:    v = b[15:14];
      4'd8:    v = b[17:16];
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic [11:0] line_map(
    input logic [2:0] l
  );
    logic [11:0] m;
    unique case (l)
      3'd0:    m = {4'd0, 4'd1, 4'd2};
      3'd1:    m = {4'd3, 4'd4, 4'd5};
      3'd2:    m = {4'd6, 4'd7, 4'd8};
      3'd3:    m = {4'd0, 4'd3, 4'd6};
      3'd4:    m = {4'd1, 4'd4, 4'd7};
      3'd5:    m = {4'd2, 4'd5, 4'd8};
      3'd6:    m = {4'd0, 4'd4, 4'd8};
      default: m = {4'd2, 4'd4, 4'd6};
    endcase
    return m;
  endfunction

  always_comb begin
    line_cells = line_map(line);
    cell_a = cell_at(bus.gameBoard, line_cells[11:8]);
    cell_b = cell_at(bus.gameBoard, line_cells[7:4]);
    cell_c = cell_at(bus.gameBoard, line_cells[3:0]);
    line_match = (cell_a != 2'b00) &&
                 (cell_a == cell_b) &&
                 (cell_b == cell_c);
  end

  assign target = cell_at(bus.gameBoard, bus.moveAddr);

  // No write enable downstream: outside the write window,
  // echo the addressed cell back so memory is left intact.
  always_comb begin
    cell_state = cell_at(bus.gameBoard, addr_q);
    unique case (1'b1)
      (state == WRITE),
      (state == SETTLE): cell_state = turn_q ? 2'b10 : 2'b11;
      default:           ;
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      line       <= 3'd0;
      move_count <= 4'd0;
      addr_q     <= 4'd0;
      turn_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= 2'b00;
      over_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.moveValid) begin
            if (bus.moveAddr > 4'd8 || target != 2'b00) begin
              err_q <= 1'b1;
            end else begin
              addr_q     <= bus.moveAddr;
              move_count <= move_count + 4'd1;
              busy_q     <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: state <= SETTLE;
        SETTLE: begin
          line  <= 3'd0;
          state <= SCAN;
        end
        SCAN: begin
          if (line_match) begin
            result_q <= cell_a;
            ack_q    <= 1'b1;
            over_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= DONE;
          end else if (line == 3'd7) begin
            ack_q  <= 1'b1;
            busy_q <= 1'b0;
            if (move_count == 4'd9) begin
              result_q <= 2'b01;
              over_q   <= 1'b1;
              state    <= DONE;
            end else begin
              turn_q <= ~turn_q;
              state  <= IDLE;
            end
          end else begin
            line <= line + 3'd1;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr      = addr_q;
  assign bus.cellState = cell_state;
  assign bus.turn      = turn_q;
  assign bus.busy      = busy_q;
  assign bus.moveAck   = ack_q;
  assign bus.moveErr   = err_q;
  assign bus.result    = result_q;
  assign bus.gameOver  = over_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl with a no-write-enable
// board memory model fed back into gameBoard.
module tb_turn_ctrl;

  logic        ph1;
  logic        reset;
  logic        mv;
  logic [3:0]  ma;
  logic [17:0] board;
  int          n_chk;
  int          n_fail;

  turn_ctrl_if bus ();

  turn_ctrl dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.moveValid = mv;
  assign bus.moveAddr  = ma;
  assign bus.gameBoard = board;

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  always @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      board <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (bus.addr == i[3:0])
          board[2*i +: 2] <= bus.cellState;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ph1);
    @(negedge ph1);
  endtask

  task automatic issue(input logic [3:0] a);
    @(negedge ph1);
    mv = 1'b1;
    ma = a;
    @(posedge ph1);
    @(negedge ph1);
    mv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ph1);
    reset = 1'b0;
    @(negedge ph1);
    reset = 1'b1;
  endtask

  task automatic play(input logic [3:0] a,
                      input logic exp_turn);
    issue(a);
    chk("play_busy", bus.busy, 1);
    step(9);
    chk("play_ack_early", bus.moveAck, 0);
    step(1);
    chk("play_ack", bus.moveAck, 1);
    chk("play_result", bus.result, 2'b00);
    chk("play_turn", bus.turn, exp_turn);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mv     = 1'b0;
    ma     = 4'd0;
    reset  = 1'b0;
    step(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.moveAck, 0);
    chk("rst_err", bus.moveErr, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_over", bus.gameOver, 0);
    chk("rst_turn", bus.turn, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_cell", bus.cellState, 0);
    reset = 1'b1;

    issue(4'd4);
    chk("m1_write_cell", bus.cellState, 2'b11);
    chk("m1_addr", bus.addr, 4);
    chk("m1_busy", bus.busy, 1);
    step(1);
    chk("m1_settle_cell", bus.cellState, 2'b11);
    step(1);
    chk("m1_board", board, 18'h00300);
    chk("m1_scan_cell", bus.cellState, 2'b11);
    step(7);
    chk("m1_ack_early", bus.moveAck, 0);
    chk("m1_busy_e9", bus.busy, 1);
    step(1);
    chk("m1_ack", bus.moveAck, 1);
    chk("m1_busy_e10", bus.busy, 0);
    chk("m1_turn", bus.turn, 1);
    chk("m1_result", bus.result, 0);
    step(1);
    chk("m1_ack_width", bus.moveAck, 0);

    issue(4'd4);
    chk("occ_err", bus.moveErr, 1);
    chk("occ_busy", bus.busy, 0);
    chk("occ_turn", bus.turn, 1);
    step(1);
    chk("occ_err_width", bus.moveErr, 0);
    chk("occ_board", board, 18'h00300);
    issue(4'd9);
    chk("oob_err", bus.moveErr, 1);
    chk("oob_addr", bus.addr, 4);
    step(1);
    chk("oob_err_width", bus.moveErr, 0);
    chk("oob_board", board, 18'h00300);

    do_reset();
    play(4'd0, 1'b1);
    play(4'd3, 1'b0);
    play(4'd1, 1'b1);
    play(4'd4, 1'b0);
    issue(4'd2);
    step(2);
    chk("win_ack_early", bus.moveAck, 0);
    chk("win_busy", bus.busy, 1);
    step(1);
    chk("win_ack", bus.moveAck, 1);
    chk("win_result", bus.result, 2'b11);
    chk("win_over", bus.gameOver, 1);
    chk("win_turn", bus.turn, 0);
    chk("win_busy_off", bus.busy, 0);
    step(1);
    chk("win_ack_width", bus.moveAck, 0);
    chk("win_board", board, 18'h002BF);
    issue(4'd5);
    chk("done_err", bus.moveErr, 0);
    chk("done_busy", bus.busy, 0);
    step(10);
    chk("done_ack", bus.moveAck, 0);
    chk("done_board", board, 18'h002BF);
    chk("done_over", bus.gameOver, 1);

    do_reset();
    play(4'd0, 1'b1);
    play(4'd1, 1'b0);
    play(4'd2, 1'b1);
    play(4'd4, 1'b0);
    play(4'd3, 1'b1);
    play(4'd5, 1'b0);
    play(4'd7, 1'b1);
    play(4'd6, 1'b0);
    issue(4'd8);
    step(9);
    chk("tie_ack_early", bus.moveAck, 0);
    step(1);
    chk("tie_ack", bus.moveAck, 1);
    chk("tie_result", bus.result, 2'b01);
    chk("tie_over", bus.gameOver, 1);
    chk("tie_turn", bus.turn, 0);
    chk("tie_board", board, 18'h3EAFB);
    issue(4'd0);
    chk("tie_late_err", bus.moveErr, 0);
    step(3);
    chk("tie_late_ack", bus.moveAck, 0);

    do_reset();
    @(negedge ph1);
    mv = 1'b1;
    ma = 4'd4;
    @(posedge ph1);
    @(negedge ph1);
    ma = 4'd0;
    step(1);
    for (int k = 2; k < 10; k++) begin
      step(1);
      chk("hold_cell", bus.cellState, 2'b11);
      chk("hold_board", board, 18'h00300);
      chk("hold_err", bus.moveErr, 0);
    end
    mv = 1'b0;
    step(1);
    chk("hold_ack", bus.moveAck, 1);
    chk("hold_board_end", board, 18'h00300);
    step(1);
    chk("hold_idle", bus.busy, 0);
    chk("hold_addr", bus.addr, 4);

    issue(4'd0);
    chk("mid_write_cell", bus.cellState, 2'b10);
    step(5);
    chk("mid_busy", bus.busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_busy_rst", bus.busy, 0);
    chk("mid_turn_rst", bus.turn, 0);
    chk("mid_addr_rst", bus.addr, 0);
    chk("mid_ack_rst", bus.moveAck, 0);
    chk("mid_err_rst", bus.moveErr, 0);
    chk("mid_result_rst", bus.result, 0);
    chk("mid_over_rst", bus.gameOver, 0);
    chk("mid_cell_rst", bus.cellState, 0);
    @(negedge ph1);
    reset = 1'b1;
    issue(4'd4);
    chk("post_write_cell", bus.cellState, 2'b11);
    step(9);
    chk("post_ack_early", bus.moveAck, 0);
    step(1);
    chk("post_ack", bus.moveAck, 1);
    chk("post_turn", bus.turn, 1);
    chk("post_board", board, 18'h00300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
